// File: rtl/pc_sequencer.sv
// Program-counter control sequencer: turns decode/execute/memory events into
// next-address selects, pipeline flushes and interrupt acknowledge.
module pc_sequencer #(
  parameter int unsigned INT_SAVE_CYCLES = 2  // legal range 1..7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intReq,
  input  logic       callD2E,
  input  logic       retE2M,
  input  logic       branchTaken,
  input  logic       hazardStall,
  output logic [1:0] pcSrc,
  output logic [1:0] firstTimeINTAfterD2E,
  output logic [1:0] firstTimeCallAfterD2E,
  output logic [1:0] firstTimeRETAfterE2M,
  output logic       flushF2D,
  output logic       flushD2E,
  output logic       intAck,
  output logic       busy
);

  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_HOLD   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INT_SAVE  = 3'd1,
    S_INT_JUMP  = 3'd2,
    S_CALL_JUMP = 3'd3,
    S_RET_HI    = 3'd4,
    S_RET_LO    = 3'd5
  } state_e;

  typedef struct packed {
    logic [1:0] pc_src;
    logic [1:0] ft_int;
    logic [1:0] ft_call;
    logic [1:0] ft_ret;
    logic       flush_f2d;
    logic       flush_d2e;
    logic       int_ack;
    logic       busy;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_pend_q, int_pend_d;
  logic             br_flag_q, br_flag_d;
  logic             st_flag_q, st_flag_d;
  ctrl_t            ctrl_q, ctrl_d;

  // State, flags and the decoded outputs all advance together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      int_pend_q <= 1'b0;
      br_flag_q  <= 1'b0;
      st_flag_q  <= 1'b0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
      br_flag_q  <= br_flag_d;
      st_flag_q  <= st_flag_d;
      ctrl_q     <= ctrl_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_pend_d = int_pend_q | intReq;
    br_flag_d  = 1'b0;
    st_flag_d  = 1'b0;
    ctrl_d     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (int_pend_q || intReq) begin
          state_d = S_INT_SAVE;
          cnt_d   = CNT_W'(INT_SAVE_CYCLES - 1);
        end else if (callD2E) begin
          state_d = S_CALL_JUMP;
        end else if (retE2M) begin
          state_d = S_RET_HI;
        end else if (branchTaken) begin
          br_flag_d = 1'b1;
        end else if (hazardStall) begin
          st_flag_d = 1'b1;
        end
      end
      S_INT_SAVE: begin
        if (cnt_q == '0) begin
          state_d = S_INT_JUMP;
          // A fresh request on the jump edge is a new interrupt, not this one.
          int_pend_d = intReq;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_INT_JUMP:  state_d = S_IDLE;
      S_CALL_JUMP: state_d = S_IDLE;
      S_RET_HI:    state_d = S_RET_LO;
      S_RET_LO:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    // Moore decode of the upcoming state, registered alongside it.
    unique case (state_d)
      S_IDLE: begin
        if (br_flag_d) begin
          ctrl_d.pc_src    = PC_BRANCH;
          ctrl_d.flush_f2d = 1'b1;
          ctrl_d.flush_d2e = 1'b1;
        end else if (st_flag_d) begin
          ctrl_d.pc_src = PC_HOLD;
        end else begin
          ctrl_d.pc_src = PC_NEXT;
        end
      end
      S_INT_SAVE: begin
        ctrl_d.pc_src    = PC_HOLD;
        ctrl_d.flush_f2d = 1'b1;
        ctrl_d.busy      = 1'b1;
      end
      S_INT_JUMP: begin
        ctrl_d.ft_int    = 2'b11;
        ctrl_d.int_ack   = 1'b1;
        ctrl_d.flush_f2d = 1'b1;
        ctrl_d.flush_d2e = 1'b1;
        ctrl_d.busy      = 1'b1;
      end
      S_CALL_JUMP: begin
        ctrl_d.ft_call   = 2'b11;
        ctrl_d.flush_f2d = 1'b1;
        ctrl_d.busy      = 1'b1;
      end
      S_RET_HI: begin
        ctrl_d.ft_ret    = 2'b11;
        ctrl_d.pc_src    = PC_HOLD;
        ctrl_d.flush_f2d = 1'b1;
        ctrl_d.flush_d2e = 1'b1;
        ctrl_d.busy      = 1'b1;
      end
      S_RET_LO: begin
        ctrl_d.ft_ret    = 2'b01;
        ctrl_d.pc_src    = PC_HOLD;
        ctrl_d.flush_f2d = 1'b1;
        ctrl_d.flush_d2e = 1'b1;
        ctrl_d.busy      = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  assign pcSrc                 = ctrl_q.pc_src;
  assign firstTimeINTAfterD2E  = ctrl_q.ft_int;
  assign firstTimeCallAfterD2E = ctrl_q.ft_call;
  assign firstTimeRETAfterE2M  = ctrl_q.ft_ret;
  assign flushF2D              = ctrl_q.flush_f2d;
  assign flushD2E              = ctrl_q.flush_d2e;
  assign intAck                = ctrl_q.int_ack;
  assign busy                  = ctrl_q.busy;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each cycle's full output vector is compared
// against a hand-derived expectation.
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic       intReq, callD2E, retE2M, branchTaken, hazardStall;
  logic [1:0] pcSrc, ftInt, ftCall, ftRet;
  logic       flushF2D, flushD2E, intAck, busy;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(.INT_SAVE_CYCLES(2)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .intReq                (intReq),
    .callD2E               (callD2E),
    .retE2M                (retE2M),
    .branchTaken           (branchTaken),
    .hazardStall           (hazardStall),
    .pcSrc                 (pcSrc),
    .firstTimeINTAfterD2E  (ftInt),
    .firstTimeCallAfterD2E (ftCall),
    .firstTimeRETAfterE2M  (ftRet),
    .flushF2D              (flushF2D),
    .flushD2E              (flushD2E),
    .intAck                (intAck),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcSrc, ftInt, ftCall, ftRet, flushF2D, flushD2E, intAck, busy}
  function automatic logic [11:0] ev(input logic [1:0] pc, input logic [1:0] fi,
                                     input logic [1:0] fc, input logic [1:0] fr,
                                     input logic f2d, input logic d2e,
                                     input logic ack, input logic bsy);
    return {pc, fi, fc, fr, f2d, d2e, ack, bsy};
  endfunction

  logic [11:0] obs;
  assign obs = {pcSrc, ftInt, ftCall, ftRet, flushF2D, flushD2E, intAck, busy};

  logic [11:0] E_IDLE, E_CALL, E_RHI, E_RLO, E_SAVE, E_JUMP, E_BR, E_ST;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    intReq = 0; callD2E = 0; retE2M = 0; branchTaken = 0; hazardStall = 0;
  endtask

  initial begin
    E_IDLE = ev(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    E_CALL = ev(2'b00, 2'b00, 2'b11, 2'b00, 1, 0, 0, 1);
    E_RHI  = ev(2'b10, 2'b00, 2'b00, 2'b11, 1, 1, 0, 1);
    E_RLO  = ev(2'b10, 2'b00, 2'b00, 2'b01, 1, 1, 0, 1);
    E_SAVE = ev(2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1);
    E_JUMP = ev(2'b00, 2'b11, 2'b00, 2'b00, 1, 1, 1, 1);
    E_BR   = ev(2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0);
    E_ST   = ev(2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);

    // Reset held with random inputs
    reset = 0;
    clear_inputs();
    #2;
    for (int i = 0; i < 3; i++) begin
      intReq = 1'($urandom); callD2E = 1'($urandom); retE2M = 1'($urandom);
      branchTaken = 1'($urandom); hazardStall = 1'($urandom);
      step();
      check_eq("reset_hold", obs, E_IDLE);
    end
    clear_inputs();
    #3 reset = 1;
    step();
    check_eq("idle_after_reset", obs, E_IDLE);

    // CALL: one busy cycle; a RET during it is ignored
    callD2E = 1;
    step();
    callD2E = 0;
    check_eq("call_jump", obs, E_CALL);
    retE2M = 1;
    step();
    retE2M = 0;
    check_eq("call_done", obs, E_IDLE);
    step();
    check_eq("call_ret_ignored", obs, E_IDLE);

    // RET: high half then low half
    retE2M = 1;
    step();
    retE2M = 0;
    check_eq("ret_hi", obs, E_RHI);
    step();
    check_eq("ret_lo", obs, E_RLO);
    step();
    check_eq("ret_done", obs, E_IDLE);

    // Interrupt; a branch during INT_SAVE is ignored
    intReq = 1;
    step();
    intReq = 0;
    check_eq("int_save1", obs, E_SAVE);
    branchTaken = 1;
    step();
    branchTaken = 0;
    check_eq("int_save2", obs, E_SAVE);
    step();
    check_eq("int_jump", obs, E_JUMP);
    step();
    check_eq("int_done", obs, E_IDLE);

    // Branch and stall flags: one cycle each, never busy
    branchTaken = 1;
    step();
    branchTaken = 0;
    check_eq("branch", obs, E_BR);
    hazardStall = 1;
    step();
    hazardStall = 0;
    check_eq("stall", obs, E_ST);
    step();
    check_eq("flags_clear", obs, E_IDLE);

    // Branch outranks stall
    branchTaken = 1; hazardStall = 1;
    step();
    clear_inputs();
    check_eq("prio_br_over_st", obs, E_BR);
    step();

    // Interrupt outranks call and branch
    intReq = 1; callD2E = 1; branchTaken = 1;
    step();
    clear_inputs();
    check_eq("prio_save1", obs, E_SAVE);
    step();
    check_eq("prio_save2", obs, E_SAVE);
    step();
    check_eq("prio_jump", obs, E_JUMP);
    step();
    check_eq("prio_done", obs, E_IDLE);

    // Pending interrupt raised during RET_HI
    retE2M = 1;
    step();
    retE2M = 0;
    check_eq("pend_ret_hi", obs, E_RHI);
    intReq = 1;
    step();
    intReq = 0;
    check_eq("pend_ret_lo", obs, E_RLO);
    step();
    check_eq("pend_idle_gap", obs, E_IDLE);
    step();
    check_eq("pend_save1", obs, E_SAVE);
    step();
    check_eq("pend_save2", obs, E_SAVE);
    step();
    check_eq("pend_jump", obs, E_JUMP);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("pend_single_ack", obs, E_IDLE);
    end

    // Async reset in RET_LO, with an interrupt pending that must be lost
    retE2M = 1;
    step();
    retE2M = 0;
    intReq = 1;
    step();
    intReq = 0;
    check_eq("arst_ret_lo", obs, E_RLO);
    #2 reset = 0;
    #1;
    check_eq("arst_immediate", obs, E_IDLE);
    step();
    #2 reset = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("arst_after_release", obs, E_IDLE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
